// File: rtl/carrier_loop_sequencer_pkg.sv
// Shared definitions for the carrier loop acquisition/track sequencer:
// state encodings, gain-source selector and packed gain-word field layout.
package carrier_loop_sequencer_pkg;

  typedef enum logic [2:0] {
    CLS_IDLE    = 3'd0,
    CLS_CLEAR   = 3'd1,
    CLS_ACQUIRE = 3'd2,
    CLS_VERIFY  = 3'd3,
    CLS_TRACK   = 3'd4,
    CLS_HOLD    = 3'd5
  } cls_state_e;

  // Which gain set currently drives loopGains; NONE only until the first CLEAR.
  typedef enum logic [1:0] {
    GSRC_NONE = 2'd0,
    GSRC_ACQ  = 2'd1,
    GSRC_TRK  = 2'd2
  } gain_src_e;

  // Packed gain word: {leadMan[7:0], leadExp[4:0], lagMan[7:0], lagExp[4:0]}
  localparam int LEAD_MAN_LSB = 18;
  localparam int LEAD_MAN_W   = 8;
  localparam int LEAD_EXP_LSB = 13;
  localparam int LEAD_EXP_W   = 5;
  localparam int LAG_MAN_LSB  = 5;
  localparam int LAG_MAN_W    = 8;
  localparam int LAG_EXP_LSB  = 0;
  localparam int LAG_EXP_W    = 5;

  // States from which a forced re-acquisition is honoured.
  function automatic logic is_active_state(input cls_state_e s);
    return (s == CLS_CLEAR) || (s == CLS_ACQUIRE) || (s == CLS_VERIFY) ||
           (s == CLS_TRACK) || (s == CLS_HOLD);
  endfunction

endpackage

// File: rtl/carrier_loop_sequencer_lock_qualifier.sv
// Consecutive-event counter: clear/increment with saturation and a terminal
// match flag computed on the post-update count (target 0 behaves as 1).
module lock_qualifier #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             incr,
  input  logic [CNT_W-1:0] target,
  output logic             hit
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] target_eff;

  always_comb begin
    base       = clear ? '0 : count_q;
    target_eff = (target == '0) ? CNT_W'(1) : target;
    count_d    = base;
    if (incr && (base != '1)) begin
      count_d = base + CNT_W'(1);
    end
    // clear together with incr restarts the run at one event
    hit = incr && (count_d >= target_eff);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/carrier_loop_sequencer.sv
// Carrier loop acquisition/track sequencer: walks CLEAR/ACQUIRE/VERIFY/TRACK/HOLD,
// selects the loop gain set and drives integrator clear and sweep gating.
module carrier_loop_sequencer
  import carrier_loop_sequencer_pkg::*;
#(
  parameter int GAIN_W = 26,
  parameter int CNT_W  = 8,
  parameter int TMR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clkEn,
  input  logic              enable,
  input  logic              forceAcq,
  input  logic              lockStatus,
  input  logic              lockUpdate,
  input  logic [GAIN_W-1:0] acqGains,
  input  logic [GAIN_W-1:0] trackGains,
  input  logic [CNT_W-1:0]  verifyCount,
  input  logic [CNT_W-1:0]  lossCount,
  input  logic [TMR_W-1:0]  acqTimeout,
  output logic [GAIN_W-1:0] loopGains,
  output logic              gainUpdate,
  output logic              clearAccum,
  output logic              sweepEnable,
  output logic              locked,
  output logic [2:0]        state
);

  cls_state_e        state_q, state_d;
  gain_src_e         gain_src_q, gain_src_d;
  logic [GAIN_W-1:0] loop_gains_q, loop_gains_d;
  logic              gain_update_q, gain_update_d;
  logic              clear_accum_q, clear_accum_d;
  logic              sweep_enable_q, sweep_enable_d;
  logic              locked_q, locked_d;
  logic              force_pend_q, force_pend_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  logic              lock_good;
  logic              lock_bad;
  logic              force_req;
  logic              tmo_hit;
  logic [TMR_W-1:0]  tmo_last;
  logic              verify_clear, verify_incr, verify_hit;
  logic              loss_clear, loss_incr, loss_hit;

  // Qualified lock strobes only exist on sample-rate cycles.
  always_comb begin
    lock_good = clkEn && lockUpdate && lockStatus;
    lock_bad  = clkEn && lockUpdate && !lockStatus;
    force_req = forceAcq || force_pend_q;
    tmo_last  = acqTimeout - TMR_W'(1);
    tmo_hit   = (acqTimeout != '0) && (tmr_q == tmo_last);
  end

  always_comb begin
    verify_clear = clkEn && ((state_q != CLS_VERIFY) || lock_bad);
    verify_incr  = lock_good && ((state_q == CLS_ACQUIRE) || (state_q == CLS_VERIFY));
    loss_clear   = clkEn && ((state_q != CLS_TRACK) || lock_good);
    loss_incr    = lock_bad && (state_q == CLS_TRACK);
  end

  lock_qualifier #(.CNT_W(CNT_W)) u_verify_qual (
    .clk    (clk),
    .reset  (reset),
    .clear  (verify_clear),
    .incr   (verify_incr),
    .target (verifyCount),
    .hit    (verify_hit)
  );

  lock_qualifier #(.CNT_W(CNT_W)) u_loss_qual (
    .clk    (clk),
    .reset  (reset),
    .clear  (loss_clear),
    .incr   (loss_incr),
    .target (lossCount),
    .hit    (loss_hit)
  );

  // Next-state: disable beats a forced restart, which beats normal flow.
  always_comb begin
    state_d = state_q;
    if (clkEn) begin
      if (!enable) begin
        state_d = CLS_IDLE;
      end else if (force_req && is_active_state(state_q)) begin
        state_d = CLS_CLEAR;
      end else begin
        case (state_q)
          CLS_IDLE:    state_d = CLS_CLEAR;
          CLS_CLEAR:   state_d = CLS_ACQUIRE;
          CLS_ACQUIRE: begin
            if (lock_good) begin
              state_d = verify_hit ? CLS_TRACK : CLS_VERIFY;
            end else if (tmo_hit) begin
              state_d = CLS_CLEAR;
            end
          end
          CLS_VERIFY: begin
            if (lock_good && verify_hit) begin
              state_d = CLS_TRACK;
            end else if (lock_bad) begin
              state_d = CLS_ACQUIRE;
            end
          end
          CLS_TRACK: begin
            if (loss_hit) begin
              state_d = CLS_HOLD;
            end
          end
          CLS_HOLD:    state_d = CLS_CLEAR;
          default:     state_d = CLS_IDLE;
        endcase
      end
    end
  end

  // Forced restarts arriving between sample-rate cycles wait for the next one.
  always_comb begin
    force_pend_d = force_pend_q;
    if (clkEn) begin
      force_pend_d = 1'b0;
    end else if (forceAcq) begin
      force_pend_d = 1'b1;
    end
  end

  // The acquisition timer only runs while ACQUIRE persists; any entry restarts it.
  always_comb begin
    tmr_d = tmr_q;
    if (clkEn) begin
      if ((state_q == CLS_ACQUIRE) && (state_d == CLS_ACQUIRE)) begin
        tmr_d = (tmr_q == '1) ? tmr_q : tmr_q + TMR_W'(1);
      end else begin
        tmr_d = '0;
      end
    end
  end

  // Outputs are registered images of the next state so they line up with state.
  always_comb begin
    gain_src_d = gain_src_q;
    if (clkEn) begin
      if (state_d == CLS_CLEAR) begin
        gain_src_d = GSRC_ACQ;
      end else if ((state_d == CLS_TRACK) && (state_q != CLS_TRACK)) begin
        gain_src_d = GSRC_TRK;
      end
    end

    case (gain_src_d)
      GSRC_ACQ: loop_gains_d = acqGains;
      GSRC_TRK: loop_gains_d = trackGains;
      default:  loop_gains_d = '0;
    endcase

    gain_update_d  = (gain_src_d != gain_src_q);
    clear_accum_d  = clkEn && (state_d == CLS_CLEAR);
    sweep_enable_d = (state_d == CLS_ACQUIRE);
    locked_d       = (state_d == CLS_TRACK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= CLS_IDLE;
      gain_src_q     <= GSRC_NONE;
      loop_gains_q   <= '0;
      gain_update_q  <= 1'b0;
      clear_accum_q  <= 1'b0;
      sweep_enable_q <= 1'b0;
      locked_q       <= 1'b0;
      force_pend_q   <= 1'b0;
      tmr_q          <= '0;
    end else begin
      state_q        <= state_d;
      gain_src_q     <= gain_src_d;
      loop_gains_q   <= loop_gains_d;
      gain_update_q  <= gain_update_d;
      clear_accum_q  <= clear_accum_d;
      sweep_enable_q <= sweep_enable_d;
      locked_q       <= locked_d;
      force_pend_q   <= force_pend_d;
      tmr_q          <= tmr_d;
    end
  end

  assign loopGains   = loop_gains_q;
  assign gainUpdate  = gain_update_q;
  assign clearAccum  = clear_accum_q;
  assign sweepEnable = sweep_enable_q;
  assign locked      = locked_q;
  assign state       = state_q;

endmodule

// File: tb/tb_carrier_loop_sequencer.sv
// Directed bench for carrier_loop_sequencer: hand-computed expectations for
// acquisition, verify, loss, timeout, forced restart and reset scenarios.
module tb_carrier_loop_sequencer;

  localparam int GAIN_W = 26;
  localparam int CNT_W  = 8;
  localparam int TMR_W  = 16;

  localparam logic [GAIN_W-1:0] ACQ_G  = 26'h0ABCDEF;
  localparam logic [GAIN_W-1:0] TRK_G  = 26'h1234567;
  localparam logic [GAIN_W-1:0] TRK_G2 = 26'h2AAAAAA;

  logic              clk;
  logic              reset;
  logic              clk_en;
  logic              enable;
  logic              force_acq;
  logic              lock_status;
  logic              lock_update;
  logic [GAIN_W-1:0] acq_gains;
  logic [GAIN_W-1:0] track_gains;
  logic [CNT_W-1:0]  verify_count;
  logic [CNT_W-1:0]  loss_count;
  logic [TMR_W-1:0]  acq_timeout;
  logic [GAIN_W-1:0] loop_gains;
  logic              gain_update;
  logic              clear_accum;
  logic              sweep_enable;
  logic              locked;
  logic [2:0]        state;

  int checks;
  int failures;

  carrier_loop_sequencer #(
    .GAIN_W (GAIN_W),
    .CNT_W  (CNT_W),
    .TMR_W  (TMR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clkEn       (clk_en),
    .enable      (enable),
    .forceAcq    (force_acq),
    .lockStatus  (lock_status),
    .lockUpdate  (lock_update),
    .acqGains    (acq_gains),
    .trackGains  (track_gains),
    .verifyCount (verify_count),
    .lossCount   (loss_count),
    .acqTimeout  (acq_timeout),
    .loopGains   (loop_gains),
    .gainUpdate  (gain_update),
    .clearAccum  (clear_accum),
    .sweepEnable (sweep_enable),
    .locked      (locked),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // Advance n clocks; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic upd(input logic good);
    lock_update = 1'b1;
    lock_status = good;
    tick(1);
    lock_update = 1'b0;
    lock_status = 1'b0;
  endtask

  task automatic en_tick();
    clk_en = 1'b1;
    tick(1);
    clk_en = 1'b0;
    tick(3);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    clk_en       = 1'b1;
    enable       = 1'b0;
    force_acq    = 1'b0;
    lock_status  = 1'b0;
    lock_update  = 1'b0;
    acq_gains    = ACQ_G;
    track_gains  = TRK_G;
    verify_count = 8'd4;
    loss_count   = 8'd3;
    acq_timeout  = '0;
    tick(3);

    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_gains", 32'(loop_gains), 32'd0);
    check_eq("rst_gupd", 32'(gain_update), 32'd0);
    check_eq("rst_clr", 32'(clear_accum), 32'd0);
    check_eq("rst_sweep", 32'(sweep_enable), 32'd0);
    check_eq("rst_locked", 32'(locked), 32'd0);

    // Start-up: CLEAR on the first clkEn edge, ACQUIRE on the second.
    reset  = 1'b0;
    enable = 1'b1;
    tick(1);
    check_eq("c1_state", 32'(state), 32'd1);
    check_eq("c1_clr", 32'(clear_accum), 32'd1);
    check_eq("c1_gupd", 32'(gain_update), 32'd1);
    check_eq("c1_gains", 32'(loop_gains), 32'(ACQ_G));
    tick(1);
    check_eq("c2_state", 32'(state), 32'd2);
    check_eq("c2_sweep", 32'(sweep_enable), 32'd1);
    check_eq("c2_clr", 32'(clear_accum), 32'd0);
    check_eq("c2_gupd", 32'(gain_update), 32'd0);

    // Two good updates, one bad: back to ACQUIRE without a clear.
    upd(1'b1);
    check_eq("v1_state", 32'(state), 32'd3);
    check_eq("v1_sweep", 32'(sweep_enable), 32'd0);
    upd(1'b1);
    check_eq("v2_state", 32'(state), 32'd3);
    upd(1'b0);
    check_eq("vbad_state", 32'(state), 32'd2);
    check_eq("vbad_clr", 32'(clear_accum), 32'd0);
    check_eq("vbad_sweep", 32'(sweep_enable), 32'd1);

    // A full fresh run of four good updates is needed.
    upd(1'b1);
    upd(1'b1);
    upd(1'b1);
    check_eq("v3_state", 32'(state), 32'd3);
    check_eq("v3_gains", 32'(loop_gains), 32'(ACQ_G));
    upd(1'b1);
    check_eq("trk_state", 32'(state), 32'd4);
    check_eq("trk_locked", 32'(locked), 32'd1);
    check_eq("trk_gains", 32'(loop_gains), 32'(TRK_G));
    check_eq("trk_gupd", 32'(gain_update), 32'd1);
    track_gains = TRK_G2;
    tick(1);
    check_eq("trk_gupd_off", 32'(gain_update), 32'd0);
    check_eq("trk_gains_live", 32'(loop_gains), 32'(TRK_G2));

    // Loss qualification with lossCount=3.
    upd(1'b0);
    upd(1'b0);
    upd(1'b1);
    upd(1'b0);
    upd(1'b0);
    check_eq("loss_hold_state", 32'(state), 32'd4);
    upd(1'b0);
    check_eq("hold_state", 32'(state), 32'd5);
    check_eq("hold_locked", 32'(locked), 32'd0);
    tick(1);
    check_eq("reclr_state", 32'(state), 32'd1);
    check_eq("reclr_clr", 32'(clear_accum), 32'd1);
    check_eq("reclr_gupd", 32'(gain_update), 32'd1);
    check_eq("reclr_gains", 32'(loop_gains), 32'(ACQ_G));
    tick(1);
    check_eq("reacq_state", 32'(state), 32'd2);

    // Timeout 10: ten ACQUIRE cycles then CLEAR, 11 clkEn per lap.
    acq_timeout = 16'd10;
    tick(9);
    check_eq("tmo_pre_state", 32'(state), 32'd2);
    tick(1);
    check_eq("tmo_state", 32'(state), 32'd1);
    check_eq("tmo_clr", 32'(clear_accum), 32'd1);
    check_eq("tmo_gupd", 32'(gain_update), 32'd0);
    tick(10);
    check_eq("tmo_lap_pre", 32'(state), 32'd2);
    tick(1);
    check_eq("tmo_lap_state", 32'(state), 32'd1);

    // Same timeout at clkEn 1-in-4: clear pulse still a single clk.
    for (int i = 0; i < 10; i++) en_tick();
    check_eq("slow_pre_state", 32'(state), 32'd2);
    clk_en = 1'b1;
    tick(1);
    check_eq("slow_state", 32'(state), 32'd1);
    check_eq("slow_clr_on", 32'(clear_accum), 32'd1);
    clk_en = 1'b0;
    tick(1);
    check_eq("slow_clr_off", 32'(clear_accum), 32'd0);
    check_eq("slow_hold_state", 32'(state), 32'd1);
    acq_timeout = '0;
    clk_en = 1'b1;
    tick(1);
    check_eq("slow_acq_state", 32'(state), 32'd2);

    // verifyCount=1: first good update goes straight to TRACK.
    verify_count = 8'd1;
    upd(1'b1);
    check_eq("vc1_state", 32'(state), 32'd4);
    check_eq("vc1_gupd", 32'(gain_update), 32'd1);

    // forceAcq latched while clkEn is low, consumed on the next clkEn.
    clk_en    = 1'b0;
    force_acq = 1'b1;
    tick(1);
    force_acq = 1'b0;
    tick(2);
    check_eq("force_wait_state", 32'(state), 32'd4);
    clk_en = 1'b1;
    tick(1);
    check_eq("force_state", 32'(state), 32'd1);
    check_eq("force_clr", 32'(clear_accum), 32'd1);
    check_eq("force_gupd", 32'(gain_update), 32'd1);
    tick(1);

    // verifyCount=0 behaves as 1; then disable beats a simultaneous forceAcq.
    verify_count = 8'd0;
    upd(1'b1);
    check_eq("vc0_state", 32'(state), 32'd4);
    force_acq = 1'b1;
    enable    = 1'b0;
    tick(1);
    force_acq = 1'b0;
    check_eq("dis_state", 32'(state), 32'd0);
    check_eq("dis_locked", 32'(locked), 32'd0);
    check_eq("dis_clr", 32'(clear_accum), 32'd0);
    enable = 1'b1;
    tick(1);
    check_eq("reen_state", 32'(state), 32'd1);
    tick(1);

    // Reset mid-VERIFY with clkEn low: everything back to reset values.
    verify_count = 8'd4;
    upd(1'b1);
    check_eq("mid_verify_state", 32'(state), 32'd3);
    reset  = 1'b1;
    clk_en = 1'b0;
    tick(1);
    check_eq("mrst_state", 32'(state), 32'd0);
    check_eq("mrst_gains", 32'(loop_gains), 32'd0);
    check_eq("mrst_gupd", 32'(gain_update), 32'd0);
    check_eq("mrst_clr", 32'(clear_accum), 32'd0);
    check_eq("mrst_sweep", 32'(sweep_enable), 32'd0);
    check_eq("mrst_locked", 32'(locked), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/carrier_loop_sequencer.md
Name: carrier_loop_sequencer

Overview:
Acquisition/track sequencer for the carrier loop filter. It runs the loop through clear, acquire, verify and track phases and selects the acquisition or tracking lead/lag gain set. It pulses the integrator clear and gates the frequency sweep, driven by the lock-detector status and update strobe. It sits between the carrier loop register bank (configuration source) and the loop filter datapath (gain/clear/sweep sink).

Parameters:
GAIN_W, 26, packed gain word width {leadMan[7:0], leadExp[4:0], lagMan[7:0], lagExp[4:0]}
CNT_W, 8, width of verify/loss qualification counters
TMR_W, 16, width of acquisition timeout timer (counts clkEn cycles)

Ports:
clk  in  1  datapath clock
reset  in  1  synchronous active-high reset
clkEn  in  1  sample-rate enable; all counters/FSM advance only when high
enable  in  1  sequencer enable; low forces IDLE
forceAcq  in  1  single-cycle request to restart acquisition
lockStatus  in  1  lock detector output (level)
lockUpdate  in  1  single-cycle strobe: lockStatus re-evaluated this cycle
acqGains  in  GAIN_W  acquisition gain set
trackGains  in  GAIN_W  tracking gain set
verifyCount  in  CNT_W  consecutive locked updates required to enter TRACK
lossCount  in  CNT_W  consecutive unlocked updates required to leave TRACK
acqTimeout  in  TMR_W  clkEn cycles in ACQUIRE before forced re-clear; 0 = no timeout
loopGains  out  GAIN_W  gain set applied to loop filter
gainUpdate  out  1  one-cycle pulse when loopGains changes
clearAccum  out  1  one-cycle integrator clear pulse
sweepEnable  out  1  high while in ACQUIRE
locked  out  1  high in TRACK
state  out  3  FSM state for status readback

Behaviour:
- Decided interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=IDLE(0), loopGains=0, gainUpdate=0, clearAccum=0, sweepEnable=0, locked=0. All counters 0.
- State encoding: IDLE=0, CLEAR=1, ACQUIRE=2, VERIFY=3, TRACK=4, HOLD=5. Other codes go to IDLE on the next clkEn.
- All outputs are registered. Transitions are evaluated only on cycles with clkEn=1. lockUpdate is only honoured when it coincides with clkEn.
- IDLE: sweepEnable=0, locked=0. If enable=1 -> CLEAR.
- CLEAR: lasts exactly one clkEn cycle.
  - clearAccum pulses for exactly one clk cycle, the cycle CLEAR is entered.
  - loopGains<=acqGains with gainUpdate pulse.
  - Timer cleared. -> ACQUIRE.
- ACQUIRE: sweepEnable=1; timer increments each clkEn.
  - lockUpdate & lockStatus -> VERIFY with verify counter=1.
  - Else if acqTimeout!=0 and timer==acqTimeout-1 -> CLEAR.
- VERIFY: sweepEnable=0; loopGains held at acqGains.
  - lockUpdate & lockStatus: counter++. When counter reaches verifyCount -> TRACK and loopGains<=trackGains with gainUpdate.
  - lockUpdate & !lockStatus -> ACQUIRE; counter and timer cleared; no clear pulse.
  - verifyCount of 0 or 1: the first qualifying update goes straight to TRACK.
- TRACK: locked=1.
  - lockUpdate & !lockStatus: loss counter++.
  - lockUpdate & lockStatus: loss counter=0.
  - Loss counter reaches lossCount (0 treated as 1) -> HOLD.
- HOLD: locked=0 for one clkEn cycle -> CLEAR (re-acquire with a fresh integrator).
- Priority, highest first: reset > enable=0 (-> IDLE next clkEn, outputs de-asserted) > forceAcq (-> CLEAR from any non-IDLE state) > normal transitions.
  - forceAcq is latched if clkEn is low and consumed on the next clkEn.
- gainUpdate pulses only when the selected gain set changes source. acqGains/trackGains changing while selected propagate to loopGains next clk with no pulse.
- Counters saturate at all-ones. The timer does not wrap.
- Reset mid-operation: the next cycle is IDLE with every output at its reset value, regardless of clkEn.

Decomposition:
- Shared package: state encodings (CLS_IDLE..CLS_HOLD) and gain-word field offsets (lead mantissa/exponent, lag mantissa/exponent).
- One natural sub-module: lock_qualifier. It is a consecutive-event counter with count/clear/saturate and a terminal-match output, instantiated twice (verify and loss).

Test Plan:
- reset, then enable=1, clkEn=1 continuous, acqGains=26'h0ABCDEF -> CLEAR on cycle 1; clearAccum one pulse; loopGains=26'h0ABCDEF with gainUpdate; ACQUIRE on cycle 2 with sweepEnable=1.
- ACQUIRE, verifyCount=4, four lockUpdate&lockStatus strobes -> TRACK after the 4th; locked=1; loopGains=trackGains; one gainUpdate pulse.
- VERIFY after 2 good updates, then one lockUpdate with lockStatus=0 -> ACQUIRE; no clearAccum; a later 4 good updates still needed for TRACK.
- TRACK, lossCount=3: bad, bad, good, bad, bad -> stays TRACK. A third consecutive bad -> HOLD, then CLEAR with clearAccum pulse, then ACQUIRE.
- acqTimeout=10, no lock -> CLEAR re-entered every 11 clkEn cycles. With clkEn 1-in-4, clearAccum still lasts a single clk cycle.
- forceAcq in TRACK with clkEn low -> latched; CLEAR on the next clkEn. A simultaneous enable=0 -> IDLE wins. Reset asserted mid-VERIFY -> all outputs 0 next cycle.
